// File: rtl/ekf_stage_sched_if.sv
// Host/RSA-facing signal bundle for ekf_stage_sched.
// slave is the scheduler side; master is the host + RSA side.
interface ekf_stage_sched_if #(
    parameter int unsigned ROW_LEN = 10
);
    logic               req_val;
    logic               req_rdy;
    logic [2:0]         req_stage;
    logic [ROW_LEN-1:0] req_lk;
    logic [2:0]         stage_val;
    logic [2:0]         stage_rdy;
    logic               stage_done;
    logic [ROW_LEN-1:0] landmark_num;
    logic [ROW_LEN-1:0] l_k;
    logic               busy;
    logic               done_pulse;
    logic               err;
    logic [1:0]         err_code;

    modport slave (
        input  req_val, req_stage, req_lk, stage_rdy, stage_done,
        output req_rdy, stage_val, landmark_num, l_k, busy, done_pulse, err, err_code
    );

    modport master (
        output req_val, req_stage, req_lk, stage_rdy, stage_done,
        input  req_rdy, stage_val, landmark_num, l_k, busy, done_pulse, err, err_code
    );
endinterface

// File: rtl/ekf_stage_sched.sv
// EKF stage scheduler: queues PRD/NEW/UPD requests, validates, launches to RSA and retires.
// Optional watchdog on ISSUE/RUN enabled by defining STAGE_TIMEOUT_EN.
module ekf_stage_sched #(
    parameter int unsigned ROW_LEN = 10,
    parameter int unsigned QDEPTH  = 4,
    parameter int unsigned TMO_CYC = 4096
) (
    input  logic               clk,
    input  logic               sys_rst,
    ekf_stage_sched_if.slave   bus
);
    localparam int unsigned AW     = $clog2(QDEPTH);
    localparam logic [2:0]  ST_PRD = 3'b001;
    localparam logic [2:0]  ST_NEW = 3'b010;
    localparam logic [2:0]  ST_UPD = 3'b100;

    typedef enum logic [1:0] {IDLE, ISSUE, RUN, RETIRE} state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [2:0]         r_fifo_stage [QDEPTH];
    logic [ROW_LEN-1:0] r_fifo_lk    [QDEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [AW:0]        r_count;

    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic [2:0]         w_head_stage;
    logic [ROW_LEN-1:0] w_head_lk;
    logic [1:0]         w_chk_code;
    logic               w_launch;
    logic               w_tmo;

    logic [2:0]         r_cur_stage;
    logic [ROW_LEN-1:0] r_landmark_num;
    logic [ROW_LEN-1:0] r_l_k;
    logic               r_err;
    logic [1:0]         r_err_code;

    logic [2:0]         w_stage_val;
    logic               w_busy;
    logic               w_done_pulse;

    assign w_full       = (r_count == (AW+1)'(QDEPTH));
    assign w_push       = bus.req_val && !w_full;
    assign w_pop        = (r_state == IDLE) && (r_count != '0);
    assign w_head_stage = r_fifo_stage[r_rd_ptr];
    assign w_head_lk    = r_fifo_lk[r_rd_ptr];
    assign w_launch     = |(r_cur_stage & bus.stage_rdy);

    always_comb begin
        w_chk_code = 2'b00;
        if (!(w_head_stage inside {ST_PRD, ST_NEW, ST_UPD}))
            w_chk_code = 2'b01;
        else if ((w_head_stage == ST_UPD) && (w_head_lk >= r_landmark_num))
            w_chk_code = 2'b10;
        else if ((w_head_stage == ST_NEW) && (r_landmark_num == '1))
            w_chk_code = 2'b10;
    end

`ifdef STAGE_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TMO_CYC + 1);
    logic [TW-1:0] r_tmo_cnt;

    // Any state change clears the count, which covers entry to ISSUE and RUN.
    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst)
            r_tmo_cnt <= '0;
        else if (w_state_nxt != r_state)
            r_tmo_cnt <= '0;
        else if ((r_state == ISSUE) || (r_state == RUN))
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
    end

    assign w_tmo = ((r_state == ISSUE) || (r_state == RUN)) &&
                   (r_tmo_cnt == TW'(TMO_CYC - 1));
`else
    assign w_tmo = 1'b0;
`endif

    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_pop && (w_chk_code == 2'b00)) w_state_nxt = ISSUE;
            ISSUE:   if (w_launch)                       w_state_nxt = RUN;
                     else if (w_tmo)                     w_state_nxt = IDLE;
            RUN:     if (bus.stage_done)                 w_state_nxt = RETIRE;
                     else if (w_tmo)                     w_state_nxt = IDLE;
            RETIRE:                                      w_state_nxt = IDLE;
            default:                                     w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_stage_val  = '0;
        w_busy       = 1'b1;
        w_done_pulse = 1'b0;
        case (r_state)
            IDLE:    w_busy       = 1'b0;
            ISSUE:   w_stage_val  = r_cur_stage;
            RETIRE:  w_done_pulse = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_stage[r_wr_ptr] <= bus.req_stage;
            r_fifo_lk[r_wr_ptr]    <= bus.req_lk;
        end
    end

    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_cur_stage    <= '0;
            r_landmark_num <= '0;
            r_l_k          <= '0;
            r_err          <= 1'b0;
            r_err_code     <= '0;
        end else begin
            r_err <= 1'b0;
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: ;
            endcase

            if (w_pop) begin
                if (w_chk_code != 2'b00) begin
                    r_err      <= 1'b1;
                    r_err_code <= w_chk_code;
                end else begin
                    r_cur_stage <= w_head_stage;
                    if (w_head_stage == ST_UPD) r_l_k <= w_head_lk;
                end
            end

            // Only the watchdog leaves ISSUE/RUN straight to IDLE.
            if (w_tmo && (w_state_nxt == IDLE)) begin
                r_err      <= 1'b1;
                r_err_code <= 2'b11;
            end

            if ((r_state == RETIRE) && (r_cur_stage == ST_NEW))
                r_landmark_num <= r_landmark_num + ROW_LEN'(1);
        end
    end

    assign bus.req_rdy      = !w_full;
    assign bus.stage_val    = w_stage_val;
    assign bus.landmark_num = r_landmark_num;
    assign bus.l_k          = r_l_k;
    assign bus.busy         = w_busy;
    assign bus.done_pulse   = w_done_pulse;
    assign bus.err          = r_err;
    assign bus.err_code     = r_err_code;
endmodule

// File: tb/tb_ekf_stage_sched.sv
// Directed self-checking bench for ekf_stage_sched.
// Timeout scenario is exercised only when STAGE_TIMEOUT_EN is defined.
module tb_ekf_stage_sched;
    localparam int unsigned RL     = 10;
    localparam logic [2:0]  ST_PRD = 3'b001;
    localparam logic [2:0]  ST_NEW = 3'b010;
    localparam logic [2:0]  ST_UPD = 3'b100;
`ifdef STAGE_TIMEOUT_EN
    localparam int HOLD = 12;
`else
    localparam int HOLD = 20;
`endif

    logic clk     = 1'b0;
    logic sys_rst = 1'b0;
    int   n_cmp   = 0;
    int   n_bad   = 0;

    ekf_stage_sched_if #(.ROW_LEN(RL)) bus ();

    ekf_stage_sched #(
        .ROW_LEN (RL),
        .QDEPTH  (4),
        .TMO_CYC (16)
    ) dut (
        .clk     (clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] st, input logic [RL-1:0] lk);
        int w = 0;
        bus.req_val   = 1'b1;
        bus.req_stage = st;
        bus.req_lk    = lk;
        while (!bus.req_rdy && w < 50) begin
            tick();
            w++;
        end
        if (w == 50) chk("push_rdy_wait", 32'(bus.req_rdy), 32'd1);
        tick();
        bus.req_val = 1'b0;
    endtask

    task automatic run_new(input int k);
        push(ST_NEW, '0);
        tick();
        chk($sformatf("new%0d_sv", k), 32'(bus.stage_val), 32'd2);
        tick();
        chk($sformatf("new%0d_sv_drop", k), 32'(bus.stage_val), 32'd0);
        bus.stage_done = 1'b1;
        tick();
        bus.stage_done = 1'b0;
        chk($sformatf("new%0d_done", k), 32'(bus.done_pulse), 32'd1);
        tick();
        chk($sformatf("new%0d_lmk", k), 32'(bus.landmark_num), 32'(k));
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_sv"},   32'(bus.stage_val),    32'd0);
        chk({pfx, "_busy"}, 32'(bus.busy),         32'd0);
        chk({pfx, "_done"}, 32'(bus.done_pulse),   32'd0);
        chk({pfx, "_err"},  32'(bus.err),          32'd0);
        chk({pfx, "_code"}, 32'(bus.err_code),     32'd0);
        chk({pfx, "_lmk"},  32'(bus.landmark_num), 32'd0);
        chk({pfx, "_lk"},   32'(bus.l_k),          32'd0);
    endtask

    initial begin
        int npulse;
        int nh;
        bus.req_val    = 1'b0;
        bus.req_stage  = '0;
        bus.req_lk     = '0;
        bus.stage_rdy  = '0;
        bus.stage_done = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("rst");
        sys_rst = 1'b1;
        tick();
        chk("rst_rdy", 32'(bus.req_rdy), 32'd1);

        // Single PRD with RSA always ready
        bus.stage_rdy = 3'b111;
        push(ST_PRD, '0);
        tick();
        chk("prd_sv",   32'(bus.stage_val), 32'd1);
        chk("prd_busy", 32'(bus.busy),      32'd1);
        tick();
        chk("prd_sv_drop", 32'(bus.stage_val), 32'd0);
        repeat (4) tick();
        chk("prd_run_busy", 32'(bus.busy), 32'd1);
        bus.stage_done = 1'b1;
        tick();
        bus.stage_done = 1'b0;
        chk("prd_done", 32'(bus.done_pulse), 32'd1);
        tick();
        chk("prd_done_off", 32'(bus.done_pulse),   32'd0);
        chk("prd_idle",     32'(bus.busy),         32'd0);
        chk("prd_lmk",      32'(bus.landmark_num), 32'd0);

        for (int k = 1; k <= 3; k++) run_new(k);

        // UPD out of range, then in range
        push(ST_UPD, RL'(5));
        tick();
        chk("upd5_err",  32'(bus.err),       32'd1);
        chk("upd5_code", 32'(bus.err_code),  32'd2);
        chk("upd5_sv",   32'(bus.stage_val), 32'd0);
        chk("upd5_busy", 32'(bus.busy),      32'd0);
        tick();
        chk("upd5_err_off",  32'(bus.err),      32'd0);
        chk("upd5_code_hold", 32'(bus.err_code), 32'd2);
        push(ST_UPD, RL'(2));
        tick();
        chk("upd2_lk", 32'(bus.l_k),       32'd2);
        chk("upd2_sv", 32'(bus.stage_val), 32'd4);
        tick();
        bus.stage_done = 1'b1;
        tick();
        bus.stage_done = 1'b0;
        tick();
        chk("upd2_lmk", 32'(bus.landmark_num), 32'd3);

        // Illegal stage, then UPD at exact boundary lk == landmark_num
        push(3'b011, '0);
        tick();
        chk("ill_err",  32'(bus.err),      32'd1);
        chk("ill_code", 32'(bus.err_code), 32'd1);
        tick();
        push(ST_UPD, RL'(3));
        tick();
        chk("upd3_code", 32'(bus.err_code), 32'd2);
        chk("upd3_lk",   32'(bus.l_k),      32'd2);
        tick();

        // Fill the queue while RSA is stalled
        bus.stage_rdy = 3'b000;
        bus.req_val   = 1'b1;
        bus.req_stage = ST_PRD;
        bus.req_lk    = '0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("fill%0d_rdy", i), 32'(bus.req_rdy), 32'd1);
            tick();
        end
        chk("fill_full", 32'(bus.req_rdy), 32'd0);
        bus.req_val = 1'b0;
        chk("fill_sv", 32'(bus.stage_val), 32'd1);

        bus.stage_rdy  = 3'b111;
        bus.stage_done = 1'b1;
        npulse = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.done_pulse) npulse++;
        end
        bus.stage_done = 1'b0;
        chk("drain_pulses", 32'(npulse),           32'd5);
        chk("drain_busy",   32'(bus.busy),         32'd0);
        chk("drain_lmk",    32'(bus.landmark_num), 32'd3);

        // ISSUE hold with non-matching ready bits, then reset in RUN
        bus.stage_rdy = 3'b101;
        push(ST_NEW, '0);
        tick();
        nh = 0;
        for (int i = 0; i < HOLD; i++) begin
            if (bus.stage_val == ST_NEW) nh++;
            tick();
        end
        chk("hold_cycles", 32'(nh),            32'(HOLD));
        chk("hold_sv",     32'(bus.stage_val), 32'd2);
        bus.stage_rdy = 3'b010;
        tick();
        chk("hold_launch", 32'(bus.stage_val), 32'd0);
        chk("hold_run",    32'(bus.busy),      32'd1);
        sys_rst = 1'b0;
        #1;
        chk_reset_vals("mid");
        tick();
        tick();
        sys_rst = 1'b1;
        tick();
        bus.stage_done = 1'b1;
        tick();
        bus.stage_done = 1'b0;
        chk("post_done", 32'(bus.done_pulse), 32'd0);
        chk("post_busy", 32'(bus.busy),       32'd0);
        chk("post_rdy",  32'(bus.req_rdy),    32'd1);

`ifdef STAGE_TIMEOUT_EN
        bus.stage_rdy = 3'b111;
        push(ST_PRD, '0);
        tick();
        tick();
        repeat (15) tick();
        chk("tmo_pre_busy", 32'(bus.busy), 32'd1);
        tick();
        chk("tmo_err",  32'(bus.err),        32'd1);
        chk("tmo_code", 32'(bus.err_code),   32'd3);
        chk("tmo_busy", 32'(bus.busy),       32'd0);
        chk("tmo_done", 32'(bus.done_pulse), 32'd0);
        chk("tmo_lmk",  32'(bus.landmark_num), 32'd0);
`endif

        // Saturate landmark_num with a stream of NEW requests
        bus.stage_rdy  = 3'b111;
        bus.stage_done = 1'b1;
        bus.req_val    = 1'b1;
        bus.req_stage  = ST_NEW;
        repeat (4300) tick();
        bus.req_val = 1'b0;
        repeat (20) tick();
        bus.stage_done = 1'b0;
        chk("sat_lmk",  32'(bus.landmark_num), 32'd1023);
        chk("sat_code", 32'(bus.err_code),     32'd2);
        chk("sat_busy", 32'(bus.busy),         32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
